// File: rtl/core_65c02_pkg.sv
// Shared 65C02 core types for the bus write path: write modes, sequencer states,
// the fixed stack page, and helpers for byte selection and target addressing.
package core_65c02_pkg;

  typedef enum logic {
    WR_ABS   = 1'b0,
    WR_STACK = 1'b1
  } write_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wr_state_t;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  function automatic logic [7:0] sel_byte(input logic [23:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    sel_byte = data[7:0];
      2'd1:    sel_byte = data[15:8];
      default: sel_byte = data[23:16];
    endcase
  endfunction

  // Stack pushes walk downward within page 01; absolute writes walk upward and wrap at 64K.
  function automatic logic [15:0] byte_addr(input write_mode_t mode, input logic [15:0] base,
                                            input logic [7:0] sp, input logic [1:0] idx);
    if (mode == WR_STACK) begin
      byte_addr = {STACK_PAGE, sp - {6'd0, idx}};
    end else begin
      byte_addr = base + {14'd0, idx};
    end
  endfunction

endpackage

// File: rtl/bus_write_sequencer.sv
// Drives 65C02 write cycles (absolute stores and stack pushes) one byte per cycle.
// Define BUS_WRITE_RDY_STALL_EN to let rdy=0 stall write cycles; otherwise rdy is ignored.
module bus_write_sequencer
  import core_65c02_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [1:0]  byte_count,
  input  logic [15:0] wr_addr,
  input  logic [23:0] wr_data,
  input  logic [7:0]  sp_in,
  input  logic        rdy,
  output logic [15:0] addr_out,
  output logic [7:0]  db_out,
  output logic        rwb,
  output logic [7:0]  sp_out,
  output logic        sp_load,
  output logic        busy,
  output logic        done
);

  wr_state_t   state_q, state_d;
  write_mode_t mode_q, mode_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] base_q, base_d;
  logic [23:0] data_q, data_d;
  logic [7:0]  spReq_q, spReq_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  db_q, db_d;
  logic        rwb_q, rwb_d;
  logic [7:0]  spOut_q, spOut_d;
  logic        spLoad_q, spLoad_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        advance;

`ifdef BUS_WRITE_RDY_STALL_EN
  assign advance = rdy;
`else
  logic rdy_unused;
  assign rdy_unused = rdy;
  assign advance    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= WR_ABS;
      count_q  <= 2'd0;
      idx_q    <= 2'd0;
      base_q   <= 16'h0000;
      data_q   <= 24'h000000;
      spReq_q  <= 8'h00;
      addr_q   <= 16'h0000;
      db_q     <= 8'h00;
      rwb_q    <= 1'b1;
      spOut_q  <= 8'h00;
      spLoad_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      data_q   <= data_d;
      spReq_q  <= spReq_d;
      addr_q   <= addr_d;
      db_q     <= db_d;
      rwb_q    <= rwb_d;
      spOut_q  <= spOut_d;
      spLoad_q <= spLoad_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are registered, so each transition loads the values the bus shows next cycle.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    idx_d    = idx_q;
    base_d   = base_q;
    data_d   = data_q;
    spReq_d  = spReq_q;
    addr_d   = addr_q;
    db_d     = db_q;
    rwb_d    = rwb_q;
    spOut_d  = spOut_q;
    spLoad_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (byte_count != 2'd0)) begin
          state_d = WRITE;
          mode_d  = write_mode_t'(mode);
          count_d = byte_count;
          base_d  = wr_addr;
          data_d  = wr_data;
          spReq_d = sp_in;
          idx_d   = 2'd0;
          addr_d  = byte_addr(write_mode_t'(mode), wr_addr, sp_in, 2'd0);
          db_d    = wr_data[7:0];
          rwb_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      WRITE: begin
        if (advance) begin
          if (idx_q == count_q - 2'd1) begin
            state_d = FINISH;
            rwb_d   = 1'b1;
            done_d  = 1'b1;
            if (mode_q == WR_STACK) begin
              spLoad_d = 1'b1;
              spOut_d  = spReq_q - {6'd0, count_q};
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            addr_d = byte_addr(mode_q, base_q, spReq_q, idx_q + 2'd1);
            db_d   = sel_byte(data_q, idx_q + 2'd1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rwb_d   = 1'b1;
      end
    endcase
  end

  assign addr_out = addr_q;
  assign db_out   = db_q;
  assign rwb      = rwb_q;
  assign sp_out   = spOut_q;
  assign sp_load  = spLoad_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
